// File: rtl/read_logic_gen_if.sv
// Read-sequencer bus: pass control and back-pressure from the consumer, and
// the BRAM read port plus data qualifiers and status driven by the sequencer.
//   start_read  : one-cycle pulse that starts a pass        (master -> slave)
//   stall       : consumer back-pressure                    (master -> slave)
//   bram_addr   : BRAM read address                         (slave -> master)
//   bram_en     : BRAM read enable                          (slave -> master)
//   data_valid  : BRAM output data valid this cycle         (slave -> master)
//   data_last   : last word of a tile, qualifies data_valid (slave -> master)
//   busy        : sequencer is not idle                     (slave -> master)
//   read_done   : one-cycle pulse at the end of a pass      (slave -> master)
interface read_logic_gen_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic                  start_read;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic                  data_valid;
    logic                  data_last;
    logic                  busy;
    logic                  read_done;

    modport master (
        output start_read, stall,
        input  bram_addr, bram_en, data_valid, data_last, busy, read_done
    );

    modport slave (
        input  start_read, stall,
        output bram_addr, bram_en, data_valid, data_last, busy, read_done
    );
endinterface

// File: rtl/read_logic_gen.sv
// BRAM read-address sequencer. A pass walks NUM_TILES tiles of
// NUM_READS_PER_TILE reads each, one read per unstalled cycle, then waits out
// the BRAM latency before pulsing read_done.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : read_logic_gen_if slave (start_read/stall in; BRAM port,
//            data_valid/data_last, busy, read_done out)
module read_logic_gen #(
    parameter int unsigned NUM_READS_PER_TILE = 16,
    parameter int unsigned NUM_TILES          = 24,
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter int unsigned ADDR_STRIDE        = 24,
    parameter int unsigned BRAM_LATENCY       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    read_logic_gen_if.slave  bus
);

    localparam int unsigned OFF_W  = (NUM_READS_PER_TILE > 1) ? $clog2(NUM_READS_PER_TILE) : 1;
    localparam int unsigned TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int unsigned DRN_W  = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StReading, StDrain, StDone} state_e;

    state_e                  r_state, w_state_next;
    logic [OFF_W-1:0]        r_read_offset, w_read_offset_next;
    logic [TILE_W-1:0]       r_tile_idx, w_tile_idx_next;
    logic [DRN_W-1:0]        r_drain_cnt, w_drain_cnt_next;
    logic [BRAM_LATENCY-1:0] r_valid_pipe, r_last_pipe;
    logic                    w_bram_en, w_read_done;
    logic                    w_offset_wrap, w_tile_wrap;
    logic [ADDR_WIDTH-1:0]   w_bram_addr;

    assign w_offset_wrap = (r_read_offset == OFF_W'(NUM_READS_PER_TILE - 1));
    assign w_tile_wrap   = (r_tile_idx == TILE_W'(NUM_TILES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_read_offset <= '0;
            r_tile_idx    <= '0;
            r_drain_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_read_offset <= w_read_offset_next;
            r_tile_idx    <= w_tile_idx_next;
            r_drain_cnt   <= w_drain_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_read_offset_next = r_read_offset;
        w_tile_idx_next    = r_tile_idx;
        w_drain_cnt_next   = r_drain_cnt;
        w_bram_en          = 1'b0;
        w_read_done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start_read) w_state_next = StReading;
            end
            StReading: begin
                if (!bus.stall) begin
                    w_bram_en = 1'b1;
                    if (w_offset_wrap) begin
                        w_read_offset_next = '0;
                        if (w_tile_wrap) begin
                            // Final issue of the pass: drain the BRAM pipeline.
                            w_tile_idx_next  = '0;
                            w_drain_cnt_next = '0;
                            w_state_next     = StDrain;
                        end else begin
                            w_tile_idx_next = r_tile_idx + 1'b1;
                        end
                    end else begin
                        w_read_offset_next = r_read_offset + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Last read's data appears in the final drain cycle.
                if (r_drain_cnt == DRN_W'(BRAM_LATENCY - 1)) begin
                    w_state_next = StDone;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + 1'b1;
                end
            end
            StDone: begin
                w_read_done        = 1'b1;
                w_read_offset_next = '0;
                w_tile_idx_next    = '0;
                w_state_next       = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Valid/last shift registers model the BRAM read latency, independent of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_pipe <= '0;
            r_last_pipe  <= '0;
        end else begin
            r_valid_pipe[0] <= w_bram_en;
            r_last_pipe[0]  <= w_bram_en & w_offset_wrap;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                r_valid_pipe[i] <= r_valid_pipe[i-1];
                r_last_pipe[i]  <= r_last_pipe[i-1];
            end
        end
    end

    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
    assign w_bram_addr = ADDR_WIDTH'(r_tile_idx)
                       + ADDR_WIDTH'(r_read_offset) * ADDR_WIDTH'(ADDR_STRIDE);

    assign bus.bram_addr  = w_bram_addr;
    assign bus.bram_en    = w_bram_en;
    assign bus.data_valid = r_valid_pipe[BRAM_LATENCY-1];
    assign bus.data_last  = r_last_pipe[BRAM_LATENCY-1];
    assign bus.busy       = (r_state != StIdle);
    assign bus.read_done  = w_read_done;

endmodule

// File: tb/tb_read_logic_gen.sv
// Bench for read_logic_gen: directed passes (plain, stalled, ignored restart,
// back-to-back, mid-pass reset) followed by randomized stall/restart passes,
// all checked cycle by cycle against an issue-schedule reference model.
module tb_read_logic_gen;
    localparam int unsigned N      = 4;
    localparam int unsigned T      = 2;
    localparam int unsigned AW     = 16;
    localparam int unsigned STRIDE = 24;
    localparam int unsigned L      = 2;
    localparam int unsigned NT     = N * T;
    localparam int          MAXC   = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    read_logic_gen_if #(.ADDR_WIDTH(AW)) bus_if ();

    read_logic_gen #(
        .NUM_READS_PER_TILE(N),
        .NUM_TILES         (T),
        .ADDR_WIDTH        (AW),
        .ADDR_STRIDE       (STRIDE),
        .BRAM_LATENCY      (L)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},    32'(bus_if.bram_en),    32'd0);
        check({tag, "_valid"}, 32'(bus_if.data_valid), 32'd0);
        check({tag, "_last"},  32'(bus_if.data_last),  32'd0);
        check({tag, "_busy"},  32'(bus_if.busy),       32'd0);
        check({tag, "_done"},  32'(bus_if.read_done),  32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus_if.start_read = 1'b0;
            bus_if.stall      = 1'(($urandom & 1));
            @(negedge clk);
            check_quiet("idle");
        end
    endtask

    // Cycle 0 carries start_read; stall_m/spur_m give stall and extra start
    // pulses for cycles 0..63. The model schedules the k-th issue on the k-th
    // unstalled cycle from 1 on; read k targets tile k/N, offset k%N.
    task automatic run_pass(input logic [63:0] stall_m, input logic [63:0] spur_m,
                            output int obs_done);
        logic          en_e[MAXC];
        int            idx_e[MAXC];
        int            issued, last_c, done_c;
        logic          exp_valid, exp_last;
        logic [AW-1:0] exp_addr;
        obs_done = -1;
        issued   = 0;
        last_c   = 0;
        for (int c = 0; c < MAXC; c++) begin
            en_e[c]  = 1'b0;
            idx_e[c] = 0;
        end
        for (int c = 1; c < MAXC && issued < int'(NT); c++) begin
            if (!(c < 64 && stall_m[c])) begin
                en_e[c]  = 1'b1;
                idx_e[c] = issued;
                issued++;
                last_c = c;
            end
        end
        done_c = last_c + int'(L) + 1;
        for (int cy = 0; cy <= done_c; cy++) begin
            @(posedge clk); #1;
            bus_if.start_read = (cy == 0) ? 1'b1 : (cy < 64 ? spur_m[cy] : 1'b0);
            bus_if.stall      = (cy < 64) ? stall_m[cy] : 1'b0;
            @(negedge clk);
            exp_valid = (cy >= int'(L)) ? en_e[cy-int'(L)] : 1'b0;
            exp_last  = exp_valid && ((idx_e[cy-int'(L)] % int'(N)) == int'(N) - 1);
            check("bram_en",    32'(bus_if.bram_en),    32'(en_e[cy]));
            check("data_valid", 32'(bus_if.data_valid), 32'(exp_valid));
            check("data_last",  32'(bus_if.data_last),  32'(exp_last));
            check("busy",       32'(bus_if.busy),       32'(cy >= 1 && cy <= done_c));
            check("read_done",  32'(bus_if.read_done),  32'(cy == done_c));
            if (en_e[cy]) begin
                exp_addr = AW'(idx_e[cy] / int'(N) + (idx_e[cy] % int'(N)) * int'(STRIDE));
                check("bram_addr", 32'(bus_if.bram_addr), 32'(exp_addr));
            end
            if (bus_if.read_done === 1'b1 && obs_done < 0) obs_done = cy;
        end
    endtask

    initial begin
        int d;
        bus_if.start_read = 1'b0;
        bus_if.stall      = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_quiet("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle_cycles(2);

        run_pass(64'h0, 64'h0, d);
        check("plain_done_cycle", 32'(d), 32'd11);
        idle_cycles(1);
        run_pass(64'h18, 64'h0, d);
        check("stall_done_cycle", 32'(d), 32'd13);
        run_pass(64'h0, 64'h20, d);
        check("restart_ignored_done_cycle", 32'(d), 32'd11);
        run_pass(64'h0, 64'h0, d);
        check("back_to_back_done_cycle", 32'(d), 32'd11);

        // Mid-pass reset: outputs drop at once and the pass never completes.
        @(posedge clk); #1;
        bus_if.start_read = 1'b1;
        bus_if.stall      = 1'b0;
        for (int cy = 1; cy <= 3; cy++) begin
            @(posedge clk); #1;
            bus_if.start_read = 1'b0;
            @(negedge clk);
            check("pre_reset_en", 32'(bus_if.bram_en), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_quiet("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle_cycles(12);
        run_pass(64'h0, 64'h0, d);
        check("after_reset_done_cycle", 32'(d), 32'd11);

        for (int p = 0; p < 10; p++) begin
            logic [63:0] sm, rm;
            sm = {$urandom, $urandom} & {$urandom, $urandom};
            rm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            run_pass(sm, rm, d);
            if (($urandom & 1) != 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
